// File: rtl/find_max_pkg.sv
// rtl/find_max_pkg.sv - shared state encoding and counter sizing for the block max finder
package find_max_pkg;

  typedef enum logic [0:0] {FILL = 1'b0, DRAIN = 1'b1} fm_state_t;

  // A one-beat block still needs a 1-bit counter so arrays and compares stay well formed.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/find_block_max_if.sv
// rtl/find_block_max_if.sv - input beat / replay beat handshake bundle of the block max finder
interface find_block_max_if
  import find_max_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int LANES    = 4
);

  logic [LANES-1:0][IN_WIDTH-1:0] data_in;
  logic                           data_in_valid;
  logic                           data_in_ready;
  logic [LANES-1:0][IN_WIDTH-1:0] data_out;
  logic                           data_out_valid;
  logic                           data_out_ready;
  logic                           data_out_last;
  logic [IN_WIDTH-1:0]            max_num;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last, max_num
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last, max_num
  );

endinterface

// File: rtl/abs_max_tree.sv
// rtl/abs_max_tree.sv - combinational per-beat max over all lanes, |x| unsigned or signed
module abs_max_tree
  import find_max_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int LANES    = 4,
  parameter int ABS_MODE = 1
) (
  input  logic [LANES-1:0][IN_WIDTH-1:0] lanes,
  output logic [IN_WIDTH-1:0]            beat_max
);

  logic [LANES-1:0][IN_WIDTH-1:0] mag;
  logic [IN_WIDTH-1:0]            best;

  // Magnitude keeps full IN_WIDTH unsigned, so the most negative value maps to 2^(W-1).
  always_comb begin
    mag = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((ABS_MODE != 0) && lanes[i][IN_WIDTH-1])
        mag[i] = (~lanes[i]) + IN_WIDTH'(1);
      else
        mag[i] = lanes[i];
    end
  end

  always_comb begin
    best = mag[0];
    for (int i = 1; i < LANES; i++) begin
      if (ABS_MODE != 0) begin
        if (mag[i] > best) best = mag[i];
      end else begin
        if ($signed(mag[i]) > $signed(best)) best = mag[i];
      end
    end
  end

  assign beat_max = best;

endmodule

// File: rtl/find_block_max.sv
// rtl/find_block_max.sv - buffers BLOCK_BEATS beats, finds the block-wide max, replays beats with it
module find_block_max
  import find_max_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int BLOCK_BEATS    = 4,
  parameter int ABS_MODE       = 1
) (
  input logic             clk,
  input logic             rst,
  find_block_max_if.slave bus
);

  localparam int               LANES    = IN_SIZE * IN_PARALLELISM;
  localparam int               CW       = cnt_width(BLOCK_BEATS);
  localparam logic [CW-1:0]    LAST_CNT = CW'(BLOCK_BEATS - 1);
  localparam logic [0:0]       S_FILL   = FILL;
  localparam logic [0:0]       S_DRAIN  = DRAIN;

  logic [0:0]                     state;
  logic [CW-1:0]                  beat_cnt;
  logic [IN_WIDTH-1:0]            run_max;
  logic [IN_WIDTH-1:0]            max_q;
  logic [IN_WIDTH-1:0]            beat_max;
  logic [IN_WIDTH-1:0]            merged;
  logic                           have_max;
  logic [LANES-1:0][IN_WIDTH-1:0] beat_buf [BLOCK_BEATS];
  logic                           in_fire;
  logic                           out_fire;
  logic                           at_last;

  abs_max_tree #(
    .IN_WIDTH (IN_WIDTH),
    .LANES    (LANES),
    .ABS_MODE (ABS_MODE)
  ) u_tree (
    .lanes    (bus.data_in),
    .beat_max (beat_max)
  );

  assign at_last  = (beat_cnt == LAST_CNT);
  assign in_fire  = bus.data_in_valid && bus.data_in_ready;
  assign out_fire = bus.data_out_valid && bus.data_out_ready;

  // Signed mode cannot seed from the reset value 0: an all-negative block would report 0.
  always_comb begin
    merged = run_max;
    if (ABS_MODE != 0) begin
      if (beat_max > run_max) merged = beat_max;
    end else begin
      if (!have_max || ($signed(beat_max) > $signed(run_max))) merged = beat_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      beat_cnt <= '0;
      run_max  <= '0;
      have_max <= 1'b0;
      max_q    <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_fire) begin
            run_max  <= merged;
            have_max <= 1'b1;
            if (at_last) begin
              state    <= S_DRAIN;
              beat_cnt <= '0;
              max_q    <= merged;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: begin
          if (out_fire) begin
            if (at_last) begin
              state    <= S_FILL;
              beat_cnt <= '0;
              run_max  <= '0;
              have_max <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Datapath storage needs no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (in_fire) beat_buf[beat_cnt] <= bus.data_in;
  end

  assign bus.data_in_ready  = (state == S_FILL) && !rst;
  assign bus.data_out_valid = (state == S_DRAIN);
  assign bus.data_out       = (state == S_DRAIN) ? beat_buf[beat_cnt] : '0;
  assign bus.max_num        = (state == S_DRAIN) ? max_q : '0;
  assign bus.data_out_last  = (state == S_DRAIN) && at_last;

endmodule

// File: tb/tb_find_block_max.sv
// tb/tb_find_block_max.sv - scoreboard bench: abs and signed 4-beat instances in lockstep, plus a 1-beat instance
module tb_find_block_max;

  typedef logic [3:0][15:0] beat_t;
  typedef struct packed {
    beat_t       data;
    logic [15:0] mx;
    logic        last;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t din, din2;
  logic  vin, vin2, rdy, rdy2;
  int    n_cmp = 0;
  int    n_mis = 0;
  exp_t  q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  find_block_max_if #(.IN_WIDTH(16), .LANES(4)) if0 ();
  find_block_max_if #(.IN_WIDTH(16), .LANES(4)) if1 ();
  find_block_max_if #(.IN_WIDTH(16), .LANES(4)) if2 ();

  assign if0.data_in = din;   assign if0.data_in_valid = vin;   assign if0.data_out_ready = rdy;
  assign if1.data_in = din;   assign if1.data_in_valid = vin;   assign if1.data_out_ready = rdy;
  assign if2.data_in = din2;  assign if2.data_in_valid = vin2;  assign if2.data_out_ready = rdy2;

  find_block_max #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .BLOCK_BEATS(4), .ABS_MODE(1))
    u_abs (.clk(clk), .rst(rst), .bus(if0.slave));
  find_block_max #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .BLOCK_BEATS(4), .ABS_MODE(0))
    u_sgn (.clk(clk), .rst(rst), .bus(if1.slave));
  find_block_max #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .BLOCK_BEATS(1), .ABS_MODE(1))
    u_one (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic beat_t mk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [15:0] mag(input logic [15:0] x);
    return x[15] ? 16'(17'h10000 - 17'(x)) : x;
  endfunction

  function automatic logic [15:0] model(input beat_t blk[4], input bit absm);
    logic [15:0] m;
    m = absm ? 16'h0000 : blk[0][0];
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 4; l++) begin
        if (absm) begin
          if (mag(blk[b][l]) > m) m = mag(blk[b][l]);
        end else if ($signed(blk[b][l]) > $signed(m)) begin
          m = blk[b][l];
        end
      end
    return m;
  endfunction

  // Feeds one block to both 4-beat instances and checks the replay; stop_after>=0 quits after that many outputs.
  task automatic run_block(input beat_t blk[4], input int pct, input int stop_after);
    logic [15:0] m0, m1;
    exp_t e, saved0, saved1;
    int   idx, popped, cyc, acc_cyc;
    logic stalled;
    m0 = model(blk, 1'b1);
    m1 = model(blk, 1'b0);
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{data: blk[i], mx: m0, last: (i == 3)});
      q1.push_back('{data: blk[i], mx: m1, last: (i == 3)});
    end
    idx = 0; popped = 0; cyc = 0; acc_cyc = -10; stalled = 1'b0;
    saved0 = '0; saved1 = '0;
    while (q0.size() > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      vin = (idx < 4);
      din = (idx < 4) ? blk[idx] : '0;
      rdy = ($urandom_range(0, 99) < pct);
      if (cyc == acc_cyc + 1) chk("latency", if0.data_out_valid, 1'b1);
      if (stalled) begin
        chk("stall_hold_abs", {if0.data_out, if0.max_num, if0.data_out_last}, saved0);
        chk("stall_hold_sgn", {if1.data_out, if1.max_num, if1.data_out_last}, saved1);
      end
      chk("lockstep_valid", if1.data_out_valid, if0.data_out_valid);
      if (if0.data_out_valid) chk("drain_in_ready", if0.data_in_ready, 1'b0);
      else                    chk("fill_in_ready", if0.data_in_ready, 1'b1);
      saved0  = {if0.data_out, if0.max_num, if0.data_out_last};
      saved1  = {if1.data_out, if1.max_num, if1.data_out_last};
      stalled = if0.data_out_valid && !rdy;
      if (vin && if0.data_in_ready) begin
        idx++;
        if (idx == 4) acc_cyc = cyc;
      end
      if (if0.data_out_valid && rdy) begin
        e = q0.pop_front();
        chk("out_abs", {if0.data_out, if0.max_num, if0.data_out_last}, e);
        e = q1.pop_front();
        chk("out_sgn", {if1.data_out, if1.max_num, if1.data_out_last}, e);
        popped++;
        if (popped == stop_after) break;
      end
    end
    if (stop_after < 0) chk("drained", q0.size(), 0);
  endtask

  initial begin
    beat_t blk[4];
    exp_t  e;
    int    acc, prev_acc, guard;

    vin = 1'b0; vin2 = 1'b0; rdy = 1'b1; rdy2 = 1'b1; din = '0; din2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", if0.data_in_ready, 1'b0);
    chk("rst_valid", if0.data_out_valid, 1'b0);
    chk("rst_outs", {if0.data_out, if0.max_num, if0.data_out_last}, 0);
    chk("rst_valid_one", if2.data_out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", if0.data_in_ready, 1'b1);
    chk("post_rst_ready_one", if2.data_in_ready, 1'b1);

    blk = '{mk(1, -2, 3, 4), mk(0, 0, -7, 1), mk(5, 5, 5, 5), mk(2, 2, 2, 2)};
    run_block(blk, 100, -1);

    blk = '{mk(-32768, 1, 2, 3), mk(100, -200, 0, 0), mk(7, 7, 7, 7), mk(0, 0, 0, 1)};
    run_block(blk, 100, -1);

    blk = '{mk(-5, -3, -8, -100), mk(-4, -4, -4, -4), mk(-32767, -9, -3, -10), mk(-6, -7, -8, -9)};
    run_block(blk, 100, -1);

    for (int i = 0; i < 4; i++) blk[i] = {$urandom(), $urandom()};
    run_block(blk, 30, -1);

    for (int i = 0; i < 4; i++) blk[i] = {$urandom(), $urandom()};
    run_block(blk, 100, 2);
    @(negedge clk);
    rst = 1'b1; vin = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", if0.data_out_valid, 1'b0);
    chk("mid_rst_ready", if0.data_in_ready, 1'b0);
    rst = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("after_rst_ready", if0.data_in_ready, 1'b1);
    blk = '{mk(1, 9, -2, 3), mk(-9, 0, 0, 4), mk(8, -8, 2, 2), mk(0, 1, 0, -1)};
    run_block(blk, 100, -1);

    acc = 0; prev_acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vin2 = 1'b1;
      din2 = {$urandom(), $urandom()};
      chk("one_excl", if2.data_in_ready & if2.data_out_valid, 1'b0);
      if (if2.data_out_valid) begin
        e = q2.pop_front();
        chk("one_out", {if2.data_out, if2.max_num, if2.data_out_last}, e);
      end
      if (if2.data_in_ready) begin
        blk = '{din2, din2, din2, din2};
        q2.push_back('{data: din2, mx: model(blk, 1'b1), last: 1'b1});
        chk("one_alternate", prev_acc, 0);
        acc++;
        prev_acc = 1;
      end else begin
        prev_acc = 0;
      end
    end
    chk("one_accept_count", acc, 6);
    guard = 0;
    while (q2.size() > 0 && guard < 20) begin
      @(negedge clk);
      vin2 = 1'b0;
      guard++;
      if (if2.data_out_valid) begin
        e = q2.pop_front();
        chk("one_out_tail", {if2.data_out, if2.max_num, if2.data_out_last}, e);
      end
    end
    chk("one_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
